microwave_timer_core: RTL
=========================

# microwave_timer_core

Sequential front end that feeds the BCD-to-seven-segment display decoder. Accepts keypad digits and shifts them into a three-digit M:SS register. Counts the time down once per 1 Hz tick while cooking. Drives the minute, seconds-tens and seconds-ones BCD digits consumed by the decoder, plus `running` and `done` status to the oven controller.

## Interface
Parameters:
- `MIN_MAX`, 9: largest legal minutes digit.
- `TENS_MAX`, 5: largest legal seconds-tens digit; also the reload value on a borrow.
- `ONES_MAX`, 9: largest legal seconds-ones digit; also the reload value on a borrow.

Ports:
- `clk`  in  1: single clock; all state updates on rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `tick`  in  1: one-cycle 1 Hz enable pulse, synchronous to `clk`.
- `key_valid`  in  1: one-cycle strobe; `key_digit` is valid this cycle.
- `key_digit`  in  4: binary keypad value.
- `start`  in  1: start or resume request (level sampled each cycle).
- `stop`  in  1: pause request; also driven by door-open.
- `clear`  in  1: cancel; zero the time.
- `bmin`  out  4: minutes BCD digit.
- `bsec_tens`  out  4: seconds-tens BCD digit.
- `bsec_ones`  out  4: seconds-ones BCD digit.
- `running`  out  1: high while in RUN.
- `done`  out  1: one-cycle pulse when the countdown reaches 0:00.

## Operation
- States: IDLE, RUN, PAUSE. Reset enters IDLE. Reset values: all digits 0, `running`=0, `done`=0.
- Key entry is accepted in IDLE and PAUSE only, and only when `key_digit` ≤ 9.
  - Shift: `bmin`←`bsec_tens`, `bsec_tens`←`bsec_ones`, `bsec_ones`←`key_digit`. The old `bmin` is discarded.
  - The key is ignored if the current `bsec_ones` > `TENS_MAX`, because it would create an illegal tens digit.
  - Digits > 9 are ignored.
  - Keys are ignored in RUN.
- IDLE/PAUSE + `start` → RUN, only if the time is ≠ 0:00; otherwise the state is unchanged.
- RUN + `stop` → PAUSE, with digits held.
- RUN + `clear` → IDLE, with digits zeroed.
- PAUSE + `clear` → IDLE, with digits zeroed.
- IDLE + `clear`: digits zeroed.
- RUN + `tick`: BCD decrement.
  - `bsec_ones` decrements. From 0 it wraps to `ONES_MAX` with a borrow.
  - The borrow decrements `bsec_tens`. From 0 it wraps to `TENS_MAX` with a borrow.
  - The borrow decrements `bmin`.
  - 0:00 is never decremented.
- Decrement result 0:00 → assert `done` for one cycle and go to IDLE.
- Priority when inputs coincide in one cycle: `clear` > `stop` > `start` > `tick` > `key_valid`.
  - RUN with `stop`+`tick`: pause, no decrement.
  - IDLE with `start`+`key_valid`: start taken, key dropped.
- All outputs are registered. Digits are always legal BCD within their max.

## Timing
- Key accepted at edge N → new digits visible after edge N.
- `start` sampled at edge N → `running`=1 after edge N.
  - A `tick` in the same cycle as `start` is ignored.
  - The first decrement happens on the first `tick` strictly after entry to RUN.
- Decrement latency: one cycle from the `tick` edge.
- 0:01 + `tick` at edge N → after edge N: digits 0:00, `done`=1, `running`=0. `done` returns to 0 after edge N+1.
- `rst_n` low at any time, including mid-RUN: immediate (asynchronous) return to reset values. Operation resumes on the first edge after deassertion.

## Structure
- Shared package `microwave_pkg`:
  - State enum `timer_state_t` with values IDLE, RUN and PAUSE.
  - Constants `BCD_W`=4, `DIGIT_MAX`=9, `SEC_TENS_MAX`=5.
- One sub-module, `bcd_digit_down`:
  - Inputs: digit, decrement enable, wrap value.
  - Outputs: next digit, borrow-out.
  - Instantiated three times in a chain.
- FSM, key shifter and status logic live in the top module.

## Test plan
- Keys 1,3,0 in IDLE → digits 1:30; `start`; 90 ticks → `done` pulses exactly once, at 0:00; `running` falls with it.
- Entry at 0:09, then key 5 → key ignored, digits stay 0:09. Key 12 → ignored. Key 0 at 0:05 → 0:50.
- RUN at 2:00, one tick → 1:59. Tick at 1:00 → 0:59.
- RUN at 0:45, `stop` and `tick` in the same cycle → PAUSE at 0:45. `start` → RUN. Next tick → 0:44.
- `start` at 0:00 → stays IDLE with `running`=0. `clear` in PAUSE at 3:12 → IDLE 0:00.
- `rst_n` pulsed low mid-RUN at 4:27, between edges → outputs 0:00, `running`=0 immediately. No `done` pulse.

Source files
------------

// File: rtl/microwave_pkg.sv
// Shared types and constants for the microwave timer front end.
package microwave_pkg;
    localparam int BCD_W        = 4;
    localparam int DIGIT_MAX    = 9;
    localparam int SEC_TENS_MAX = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } timer_state_t;
endpackage

// File: rtl/bcd_digit_down.sv
// One BCD digit of the countdown chain: decrement with wrap-and-borrow at zero.
import microwave_pkg::*;

module bcd_digit_down (
    input  logic [BCD_W-1:0] digit,
    input  logic             dec_en,
    input  logic [BCD_W-1:0] wrap_val,
    output logic [BCD_W-1:0] digit_nxt,
    output logic             borrow
);
    always_comb begin
        digit_nxt = digit;
        borrow    = 1'b0;
        if (dec_en) begin
            if (digit == '0) begin
                digit_nxt = wrap_val;
                borrow    = 1'b1;
            end else begin
                digit_nxt = digit - 1'b1;
            end
        end
    end
endmodule

// File: rtl/microwave_timer_core.sv
// M:SS keypad entry register and 1 Hz countdown feeding the seven-segment decoder.
import microwave_pkg::*;

module microwave_timer_core #(
    parameter int MIN_MAX  = DIGIT_MAX,
    parameter int TENS_MAX = SEC_TENS_MAX,
    parameter int ONES_MAX = DIGIT_MAX
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             key_valid,
    input  logic [BCD_W-1:0] key_digit,
    input  logic             start,
    input  logic             stop,
    input  logic             clear,
    output logic [BCD_W-1:0] bmin,
    output logic [BCD_W-1:0] bsec_tens,
    output logic [BCD_W-1:0] bsec_ones,
    output logic             running,
    output logic             done
);
    timer_state_t     state_q, state_d;
    logic [BCD_W-1:0] min_d, tens_d, ones_d;
    logic [BCD_W-1:0] min_dec, tens_dec, ones_dec;
    logic             ones_borrow, tens_borrow, min_borrow;
    logic             done_d, time_zero, dec_zero, key_ok;

    // The chain always computes the decremented value; the FSM decides whether to use it.
    bcd_digit_down u_ones (
        .digit(bsec_ones), .dec_en(1'b1), .wrap_val(BCD_W'(ONES_MAX)),
        .digit_nxt(ones_dec), .borrow(ones_borrow)
    );
    bcd_digit_down u_tens (
        .digit(bsec_tens), .dec_en(ones_borrow), .wrap_val(BCD_W'(TENS_MAX)),
        .digit_nxt(tens_dec), .borrow(tens_borrow)
    );
    bcd_digit_down u_min (
        .digit(bmin), .dec_en(tens_borrow), .wrap_val(BCD_W'(MIN_MAX)),
        .digit_nxt(min_dec), .borrow(min_borrow)
    );

    assign time_zero = (bmin == '0) && (bsec_tens == '0) && (bsec_ones == '0);
    assign dec_zero  = (min_dec == '0) && (tens_dec == '0) && (ones_dec == '0);
    // A ones digit above the tens max would shift into an illegal tens digit.
    assign key_ok    = (key_digit <= BCD_W'(DIGIT_MAX)) && (bsec_ones <= BCD_W'(TENS_MAX));

    always_comb begin
        state_d = state_q;
        min_d   = bmin;
        tens_d  = bsec_tens;
        ones_d  = bsec_ones;
        done_d  = 1'b0;
        if (clear) begin
            state_d = IDLE;
            min_d   = '0;
            tens_d  = '0;
            ones_d  = '0;
        end else if (stop) begin
            if (state_q == RUN) state_d = PAUSE;
        end else if (start && state_q != RUN) begin
            if (!time_zero) state_d = RUN;
        end else if (tick && state_q == RUN && !time_zero) begin
            min_d  = min_dec;
            tens_d = tens_dec;
            ones_d = ones_dec;
            if (dec_zero) begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
        end else if (key_valid && state_q != RUN && key_ok) begin
            min_d  = bsec_tens;
            tens_d = bsec_ones;
            ones_d = key_digit;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            bmin      <= '0;
            bsec_tens <= '0;
            bsec_ones <= '0;
            running   <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            bmin      <= min_d;
            bsec_tens <= tens_d;
            bsec_ones <= ones_d;
            running   <= (state_d == RUN);
            done      <= done_d;
        end
    end

    logic unused_borrow;
    assign unused_borrow = min_borrow;
endmodule
